// File: rtl/fetch_pc_pkg.sv
// Shared definitions for the instruction-fetch PC stage:
// fetch states and next-PC select codes.
package fetch_pc_pkg;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_SRC_SEQ = 2'b00,
        PC_SRC_BR  = 2'b01,
        PC_SRC_J   = 2'b10,
        PC_SRC_JR  = 2'b11
    } pc_src_e;

    function automatic logic low_bits_set(input logic [1:0] lsb);
        return |lsb;
    endfunction

endpackage

// File: rtl/fetch_pc_stage_mux.sv
// Four-input select used to pick the redirect target
// (sequential, branch, jump, register-indirect).
module mux_4to1
    import fetch_pc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       control,
    input  logic [WIDTH-1:0] I_0,
    input  logic [WIDTH-1:0] I_1,
    input  logic [WIDTH-1:0] I_2,
    input  logic [WIDTH-1:0] I_3,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = I_0;
        unique case (control)
            PC_SRC_SEQ: out = I_0;
            PC_SRC_BR:  out = I_1;
            PC_SRC_J:   out = I_2;
            PC_SRC_JR:  out = I_3;
        endcase
    end

endmodule

// File: rtl/fetch_pc_stage.sv
// Fetch front end: owns the PC, runs req/ack reads to instruction
// memory and hands instruction+PC to decode over valid/ready.
module fetch_pc_stage
    import fetch_pc_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0040_0000,
    parameter int               PC_INC   = 4
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             redirect,
    input  logic [1:0]       pc_src,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [WIDTH-1:0] jump_target,
    input  logic [WIDTH-1:0] jr_target,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] instr_out,
    output logic [WIDTH-1:0] pc_out,
    output logic             misalign
);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] pc_out_q, pc_out_d;
    logic             squash_q, squash_d;
    logic             req_q, req_d;
    logic             valid_q, valid_d;
    logic             misalign_q, misalign_d;

    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] inc_pc;
    logic [WIDTH-1:0] target;

    assign seq_pc = pc_out_q + WIDTH'(PC_INC);
    assign inc_pc = pc_q + WIDTH'(PC_INC);

    mux_4to1 #(.WIDTH(WIDTH)) u_target_mux (
        .control (pc_src),
        .I_0     (seq_pc),
        .I_1     (branch_target),
        .I_2     (jump_target),
        .I_3     (jr_target),
        .out     (target)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
        squash_d   = squash_q;
        req_d      = req_q;
        valid_d    = valid_q;
        misalign_d = 1'b0;

        if (redirect) begin
            pc_d       = {target[WIDTH-1:2], 2'b00};
            misalign_d = low_bits_set(target[1:0]);
            state_d    = S_FETCH;
            valid_d    = 1'b0;
            if (state_q == S_HOLD) begin
                req_d = 1'b1;
            end else if (imem_ack) begin
                squash_d = 1'b0;
                req_d    = 1'b1;
            end else if (req_q || squash_q) begin
                // a reply is still owed; drop it when it lands
                squash_d = 1'b1;
                req_d    = 1'b0;
            end else begin
                req_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (imem_ack && squash_q) begin
                        squash_d = 1'b0;
                        req_d    = 1'b1;
                    end else if (imem_ack && req_q) begin
                        instr_d  = imem_rdata;
                        pc_out_d = pc_q;
                        pc_d     = inc_pc;
                        valid_d  = 1'b1;
                        req_d    = 1'b0;
                        state_d  = S_HOLD;
                    end else if (!squash_q) begin
                        req_d = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (ready_in) begin
                        valid_d = 1'b0;
                        req_d   = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            pc_out_q   <= '0;
            squash_q   <= 1'b0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            squash_q   <= squash_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign valid_out = valid_q;
    assign instr_out = instr_q;
    assign pc_out    = pc_out_q;
    assign misalign  = misalign_q;

endmodule
